// File: rtl/pwm_capture_l1.sv
// PWM period/high-time capture feeding a bit-serial restoring divider that yields
// a fixed-point duty cycle, with stuck-waveform timeout reporting.
module pwm_capture_l1 #(
  parameter int DATA_WIDTH         = 32,
  parameter int DATA_WIDTH_DECIMAL = 20
) (
  input  logic                  aclk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  pwm,
  input  logic [31:0]           timeout,
  output logic [31:0]           period_meas,
  output logic [31:0]           high_meas,
  output logic [DATA_WIDTH-1:0] duty,
  output logic                  valid,
  output logic                  stuck,
  output logic                  overrun
);

  localparam int QW = DATA_WIDTH_DECIMAL + 1;
  localparam int BW = (QW > 1) ? $clog2(QW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(QW - 1);
  localparam logic [DATA_WIDTH-1:0] DUTY_ONE = DATA_WIDTH'(1) << DATA_WIDTH_DECIMAL;

  typedef enum logic {IDLE, DIV} state_t;

  state_t          state_q, state_d;
  logic            prev_q, prev_d;
  logic            armed_q, armed_d;
  logic            seenFall_q, seenFall_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [31:0]     highCnt_q, highCnt_d;
  logic [32:0]     rem_q, rem_d;
  logic [31:0]     div_q, div_d;
  logic [31:0]     highCap_q, highCap_d;
  logic [QW-1:0]   quo_q, quo_d;
  logic [BW-1:0]   bitCnt_q, bitCnt_d;
  logic [31:0]     periodMeas_q, periodMeas_d;
  logic [31:0]     highMeas_q, highMeas_d;
  logic [DATA_WIDTH-1:0] duty_q, duty_d;
  logic            valid_q, valid_d;
  logic            stuck_q, stuck_d;
  logic            overrun_q, overrun_d;

  logic            rise, fall, capture, toFire;
  logic            qBit;
  logic [32:0]     remNext;
  logic [QW-1:0]   quoNext;

  assign rise    = ce & pwm & ~prev_q;
  assign fall    = ce & ~pwm & prev_q;
  assign capture = rise & armed_q & seenFall_q;
  // A rise always restarts the count, so it pre-empts any timeout on that tick.
  assign toFire  = ce & ~rise & armed_q & (timeout != 32'd0) & (cnt_q >= timeout)
                   & (state_q == IDLE);

  always_comb begin
    prev_d     = prev_q;
    armed_d    = armed_q;
    seenFall_d = seenFall_q;
    cnt_d      = cnt_q;
    highCnt_d  = highCnt_q;
    if (ce) begin
      prev_d = pwm;
    end
    if (rise) begin
      cnt_d      = 32'd1;
      armed_d    = 1'b1;
      seenFall_d = 1'b0;
    end else begin
      if (ce && armed_q && (cnt_q != 32'hFFFF_FFFF)) begin
        cnt_d = cnt_q + 32'd1;
      end
      if (fall && armed_q) begin
        highCnt_d  = cnt_q;
        seenFall_d = 1'b1;
      end
      if (toFire) begin
        armed_d    = 1'b0;
        seenFall_d = 1'b0;
      end
    end
  end

  // Remainder starts at high (<= period) so the first step yields the integer bit.
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    div_d        = div_q;
    highCap_d    = highCap_q;
    quo_d        = quo_q;
    bitCnt_d     = bitCnt_q;
    periodMeas_d = periodMeas_q;
    highMeas_d   = highMeas_q;
    duty_d       = duty_q;
    stuck_d      = stuck_q;
    overrun_d    = overrun_q;
    valid_d      = 1'b0;
    qBit         = 1'b0;
    remNext      = rem_q;
    quoNext      = quo_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          rem_d     = {1'b0, highCnt_q};
          div_d     = cnt_q;
          highCap_d = highCnt_q;
          quo_d     = '0;
          bitCnt_d  = LAST_BIT;
          state_d   = DIV;
        end else if (toFire) begin
          periodMeas_d = '0;
          highMeas_d   = '0;
          duty_d       = pwm ? DUTY_ONE : '0;
          stuck_d      = 1'b1;
          valid_d      = 1'b1;
        end
      end
      DIV: begin
        if (capture) begin
          overrun_d = 1'b1;
        end
        qBit             = (rem_q >= {1'b0, div_q});
        remNext          = qBit ? (rem_q - {1'b0, div_q}) : rem_q;
        quoNext          = quo_q;
        quoNext[bitCnt_q] = qBit;
        rem_d            = remNext << 1;
        quo_d            = quoNext;
        if (bitCnt_q == '0) begin
          periodMeas_d = div_q;
          highMeas_d   = highCap_q;
          duty_d       = DATA_WIDTH'(quoNext);
          stuck_d      = 1'b0;
          valid_d      = 1'b1;
          state_d      = IDLE;
        end else begin
          bitCnt_d = bitCnt_q - BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      prev_q       <= 1'b0;
      armed_q      <= 1'b0;
      seenFall_q   <= 1'b0;
      cnt_q        <= '0;
      highCnt_q    <= '0;
      rem_q        <= '0;
      div_q        <= '0;
      highCap_q    <= '0;
      quo_q        <= '0;
      bitCnt_q     <= '0;
      periodMeas_q <= '0;
      highMeas_q   <= '0;
      duty_q       <= '0;
      valid_q      <= 1'b0;
      stuck_q      <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      armed_q      <= armed_d;
      seenFall_q   <= seenFall_d;
      cnt_q        <= cnt_d;
      highCnt_q    <= highCnt_d;
      rem_q        <= rem_d;
      div_q        <= div_d;
      highCap_q    <= highCap_d;
      quo_q        <= quo_d;
      bitCnt_q     <= bitCnt_d;
      periodMeas_q <= periodMeas_d;
      highMeas_q   <= highMeas_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      stuck_q      <= stuck_d;
      overrun_q    <= overrun_d;
    end
  end

  assign period_meas = periodMeas_q;
  assign high_meas   = highMeas_q;
  assign duty        = duty_q;
  assign valid       = valid_q;
  assign stuck       = stuck_q;
  assign overrun     = overrun_q;

endmodule

// File: doc/pwm_capture_l1.md
Name: pwm_capture_l1

Overview:
- Measures a PWM waveform and returns its period, high time and fixed-point duty cycle.
- The PWM input is typically pwm_l1 output or a pin under test.
- Closes the loop in hardware-in-the-loop benches: a controller-driven PWM becomes a duty value for model_boost_l1-style plant models and for scoreboard checks against the PI output.
- Sampling is gated by the same ce tick that steps the modulator.

Parameters:
DATA_WIDTH, 32, width of duty output (signed fixed point, two's complement container).
DATA_WIDTH_DECIMAL, 20, fractional bits of duty; 1.0 = 2**DATA_WIDTH_DECIMAL.

Ports:
aclk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
ce  input  1  sample/count tick; pwm sampled and counters advanced only when ce=1.
pwm  input  1  PWM waveform, same clock domain, no synchroniser.
timeout  input  32  stuck-detection limit in ce ticks; 0 disables.
period_meas  output  32  last measured period in ce ticks.
high_meas  output  32  last measured high time in ce ticks.
duty  output  DATA_WIDTH  high_meas/period_meas in Q(DATA_WIDTH_DECIMAL).
valid  output  1  one-aclk pulse when outputs update.
stuck  output  1  set when last report was a timeout; cleared on next normal report.
overrun  output  1  sticky: a measurement was dropped because the divider was busy; cleared only by reset.

Behaviour:
- Reset (async, active-high): all outputs 0, prev sample 0, armed=0, seen_fall=0, cnt=0, divider IDLE.
- Edge detection on ce ticks only:
  - rise = pwm & ~prev; fall = ~pwm & prev.
  - prev <= pwm on every ce tick.
- Counter cnt, 32 bits, saturating at all-ones.
  - On a rise tick: cnt <= 1.
  - Otherwise, on a ce tick with armed=1: cnt <= cnt+1.
- Fall tick with armed=1: high_cnt <= cnt (pre-increment value); seen_fall <= 1.
- Rise tick:
  - If armed & seen_fall, capture period=cnt and high=high_cnt.
  - Then armed <= 1 and seen_fall <= 0.
  - First rise after reset or after re-arm only arms; it produces no report.
- Example: high H ticks, low L ticks -> high_meas=H, period_meas=H+L.
- Divider FSM (IDLE, DIV), runs on every aclk, independent of ce:
  - IDLE + capture on cycle k: load dividend = high<<DATA_WIDTH_DECIMAL, divisor = period; enter DIV.
  - DIV: restoring division, one quotient bit per cycle, DATA_WIDTH_DECIMAL+1 bits (quotient <= 1.0).
  - At cycle k+DATA_WIDTH_DECIMAL+2: period_meas, high_meas, duty registered together, valid=1 for one cycle; return to IDLE.
  - Quotient is truncated (floor), not rounded.
- Capture while in DIV: measurement discarded, overrun <= 1; edge/counter tracking continues unaffected.
- Timeout, with timeout!=0, armed=1, cnt>=timeout on a ce tick, FSM IDLE:
  - Report period_meas=0, high_meas=0, stuck=1, valid pulse next cycle.
  - duty = 1<<DATA_WIDTH_DECIMAL if pwm=1, else 0.
  - Then armed <= 0, seen_fall <= 0: exactly one report per stuck episode.
  - If the FSM is in DIV, the timeout is held until the FSM returns to IDLE.
- Timeout and capture on the same tick: capture wins.
- No division by zero is possible: a capture implies period >= 2.
- ce=0 indefinitely: no state change except completion of an in-flight division.

Test Plan:
- Reset, ce every 100 aclk, pwm 25 ticks high / 75 low, three periods -> first valid only after second rise; period_meas=100, high_meas=25, duty=262144; valid exactly 22 aclk after capture tick.
- Sweep high = 1, 50, 99 of 100 -> duty = floor(h*1048576/100): 10485, 524288, 1038090; stuck=0.
- pwm held 1 with timeout=500 after arming -> one valid, duty=1048576, stuck=1, period_meas=0; no further valid until the waveform resumes and two rises occur; stuck cleared on next normal report.
- ce every aclk, period 4 (2 high) -> first report correct (duty=524288), subsequent captures during DIV set overrun=1 and stay 1.
- Assert reset during DIV -> outputs 0 immediately, no valid afterwards; first report only after arm plus one full period.
- Drive pwm from pwm_l1 (period 100, comparator 40) on a shared ce -> duty=419430 steady, valid once per 100 ce ticks.
